// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and pointer-compare helpers for fifo_sync_flags
// Contents: FIFO_WIDTH / FIFO_POINTER default sizes; ptr_empty / ptr_full on
// wrap-bit binary pointers (n = address width, pointer is n+1 bits, zero-extended).
package fifo_pkg;

    localparam int FIFO_WIDTH   = 8;
    localparam int FIFO_POINTER = 12;

    function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp, input int unsigned n);
        return ((wp ^ rp) & ((32'd2 << n) - 32'd1)) == 32'd0;
    endfunction

    // Full: wrap bits differ, address bits equal.
    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp, input int unsigned n);
        return ((wp ^ rp) & ((32'd2 << n) - 32'd1)) == (32'd1 << n);
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: simple dual-port RAM, one write port and one read port on clk
// Ports: clk; reset/re (registered-read build only) reset and enable the read
// register; we/waddr/wdata write port; raddr/rdata read port.
// FIFO_FWFT_EN: read port becomes asynchronous (rdata = mem[raddr]).
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH   = FIFO_WIDTH,
    parameter int POINTER = FIFO_POINTER
) (
    input  logic               clk,
`ifndef FIFO_FWFT_EN
    input  logic               reset,
    input  logic               re,
`endif
    input  logic               we,
    input  logic [POINTER-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [POINTER-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [1 << POINTER];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

`ifdef FIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Read-before-write: a same-address write in the same edge returns old data.
    always_ff @(posedge clk or posedge reset)
        if (reset) rdata <= '0;
        else if (re) rdata <= mem[raddr];
`endif

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with exact count, level flags and sticky errors
// Ports: clk, reset (async, active-high), clr (sync flush), wr/data_in write,
// rd read (head acknowledge in FWFT), data_out, wr_full, rd_empty,
// almost_full, almost_empty, cnt (0..DEPTH), overflow, underflow (sticky).
// FIFO_FWFT_EN: data_out shows the head word combinationally while not empty.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH,
    parameter int POINTER  = FIFO_POINTER,
    parameter int AF_LEVEL = (1 << POINTER) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             wr_full,
    output logic             rd_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [POINTER:0] cnt,
    output logic             overflow,
    output logic             underflow
);

    logic [POINTER:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_q, cnt_d;
    logic             full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             write_ok, read_ok;

    // A write into a full FIFO is accepted when a read frees the slot in the same edge.
    assign write_ok = wr & (~full_q | rd);
    assign read_ok  = rd & ~empty_q;

    always_comb begin
        wr_ptr_d = clr ? '0 : wr_ptr_q + (POINTER+1)'(write_ok);
        rd_ptr_d = clr ? '0 : rd_ptr_q + (POINTER+1)'(read_ok);
        cnt_d    = clr ? '0 : cnt_q + (POINTER+1)'(write_ok) - (POINTER+1)'(read_ok);
        ovf_d    = ~clr & (ovf_q | (wr & full_q & ~rd));
        unf_d    = ~clr & (unf_q | (rd & empty_q));
        empty_d  = ptr_empty(32'(wr_ptr_d), 32'(rd_ptr_d), POINTER);
        full_d   = ptr_full(32'(wr_ptr_d), 32'(rd_ptr_d), POINTER);
        af_d     = int'(cnt_d) >= AF_LEVEL;
        ae_d     = int'(cnt_d) <= AE_LEVEL;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end

    // clr blocks the RAM read so data_out keeps its last value across a flush.
    fifo_sdp_ram #(
        .WIDTH   (WIDTH),
        .POINTER (POINTER)
    ) u_ram (
        .clk   (clk),
`ifndef FIFO_FWFT_EN
        .reset (reset),
        .re    (read_ok & ~clr),
`endif
        .we    (write_ok & ~clr),
        .waddr (wr_ptr_q[POINTER-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_q[POINTER-1:0]),
        .rdata (data_out)
    );

    assign wr_full      = full_q;
    assign rd_empty     = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign cnt          = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule
